// File: rtl/async_read_dual_port_ram_if.sv
// Bus bundle for the scratch RAM: write-port controls plus the combinational read port.
interface async_read_dual_port_ram_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3
);
  logic                  we;
  logic                  re;
  logic [DATA_WIDTH-1:0] data_in;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] data_out;

  modport master (
    output we, re, data_in, wr_addr, rd_addr,
    input  data_out
  );

  modport slave (
    input  we, re, data_in, wr_addr, rd_addr,
    output data_out
  );
endinterface

// File: rtl/async_read_dual_port_ram.sv
// 8x16 simple dual-port RAM: write on rising wr_clk, combinational read,
// whole array cleared asynchronously by clr.
module async_read_dual_port_ram #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3,
  parameter int DEPTH      = 8
) (
  input  logic                          wr_clk,
  input  logic                          clr,
  async_read_dual_port_ram_if.slave     bus
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_s;

  // Next array contents: one word replaced when we is a clean 1, otherwise hold.
  always_comb begin
    mem_d = mem_q;
    if (bus.we == 1'b1) begin
      mem_d[bus.wr_addr] = bus.data_in;
    end else begin
      mem_d = mem_q;
    end
  end

  // Storage array; clear is asynchronous and overrides any coincident write edge.
  always_ff @(posedge wr_clk or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {DATA_WIDTH{1'b0}};
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // Read port is purely combinational: no bypass of data_in, forced to zero while clearing.
  always_comb begin
    rd_data_s = {DATA_WIDTH{1'b0}};
    if ((bus.re == 1'b1) && (clr == 1'b0)) begin
      rd_data_s = mem_q[bus.rd_addr];
    end else begin
      rd_data_s = {DATA_WIDTH{1'b0}};
    end
  end

  assign bus.data_out = rd_data_s;

endmodule

// File: tb/tb_async_read_dual_port_ram.sv
// Directed self-checking bench for async_read_dual_port_ram.
module tb_async_read_dual_port_ram;

  logic wr_clk;
  logic clr;
  int   n_checks;
  int   n_fail;

  async_read_dual_port_ram_if #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) bus ();

  async_read_dual_port_ram #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .DEPTH(8)) dut (
    .wr_clk (wr_clk),
    .clr    (clr),
    .bus    (bus)
  );

  initial wr_clk = 1'b0;
  always #5 wr_clk = ~wr_clk;

  task automatic write_word(input logic [2:0] addr, input logic [15:0] data);
    @(negedge wr_clk);
    bus.we      = 1'b1;
    bus.wr_addr = addr;
    bus.data_in = data;
    @(posedge wr_clk);
    #1;
    bus.we = 1'b0;
  endtask

  task automatic test_reset();
    clr         = 1'b1;
    bus.we      = 1'b0;
    bus.re      = 1'b1;
    bus.data_in = 16'h0000;
    bus.wr_addr = 3'd0;
    bus.rd_addr = 3'd0;
    #12;
    for (int i = 0; i < 8; i++) begin
      bus.rd_addr = 3'(i);
      #1;
      n_checks++;
      if (bus.data_out !== 16'h0000) begin
        n_fail++;
        $display("FAIL reset_read[%0d]: got %h expected 0000", i, bus.data_out);
      end
    end
    @(negedge wr_clk);
    clr = 1'b0;
  endtask

  task automatic test_clear();
    write_word(3'd5, 16'hBEEF);
    bus.re      = 1'b1;
    bus.rd_addr = 3'd5;
    #1;
    n_checks++;
    if (bus.data_out !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL clear_pre: got %h expected beef", bus.data_out);
    end
    clr = 1'b1;
    #25;
    n_checks++;
    if (bus.data_out !== 16'h0000) begin
      n_fail++;
      $display("FAIL clear_during: got %h expected 0000", bus.data_out);
    end
    #25;
    clr = 1'b0;
    #1;
    n_checks++;
    if (bus.data_out !== 16'h0000) begin
      n_fail++;
      $display("FAIL clear_after: got %h expected 0000", bus.data_out);
    end
  endtask

  task automatic test_fill_readback();
    for (int i = 0; i < 8; i++) begin
      write_word(3'(i), 16'(i + 3));
    end
    bus.re = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.rd_addr = 3'(i);
      #1;
      n_checks++;
      if (bus.data_out !== 16'(i + 3)) begin
        n_fail++;
        $display("FAIL fill_read[%0d]: got %h expected %h", i, bus.data_out, 16'(i + 3));
      end
    end
  endtask

  task automatic test_re_gating();
    write_word(3'd2, 16'h000C);
    bus.re      = 1'b0;
    bus.rd_addr = 3'd2;
    #1;
    n_checks++;
    if (bus.data_out !== 16'h0000) begin
      n_fail++;
      $display("FAIL re_low: got %h expected 0000", bus.data_out);
    end
    bus.re = 1'b1;
    #1;
    n_checks++;
    if (bus.data_out !== 16'h000C) begin
      n_fail++;
      $display("FAIL re_high: got %h expected 000c", bus.data_out);
    end
  endtask

  task automatic test_write_disable();
    @(negedge wr_clk);
    bus.we      = 1'b0;
    bus.wr_addr = 3'd4;
    bus.data_in = 16'hFFFF;
    repeat (3) @(posedge wr_clk);
    #1;
    bus.re      = 1'b1;
    bus.rd_addr = 3'd4;
    #1;
    n_checks++;
    if (bus.data_out !== 16'h0007) begin
      n_fail++;
      $display("FAIL write_disable: got %h expected 0007", bus.data_out);
    end
  endtask

  task automatic test_same_addr();
    write_word(3'd6, 16'h0001);
    @(negedge wr_clk);
    bus.re      = 1'b1;
    bus.rd_addr = 3'd6;
    bus.wr_addr = 3'd6;
    bus.data_in = 16'h0009;
    bus.we      = 1'b1;
    #1;
    n_checks++;
    if (bus.data_out !== 16'h0001) begin
      n_fail++;
      $display("FAIL same_addr_before: got %h expected 0001", bus.data_out);
    end
    @(posedge wr_clk);
    #1;
    bus.we = 1'b0;
    n_checks++;
    if (bus.data_out !== 16'h0009) begin
      n_fail++;
      $display("FAIL same_addr_after: got %h expected 0009", bus.data_out);
    end
  endtask

  task automatic test_clr_during_write();
    @(negedge wr_clk);
    bus.we      = 1'b1;
    bus.wr_addr = 3'd1;
    bus.data_in = 16'h1234;
    clr         = 1'b1;
    @(posedge wr_clk);
    #1;
    @(negedge wr_clk);
    bus.we = 1'b0;
    clr    = 1'b0;
    @(posedge wr_clk);
    #1;
    bus.re      = 1'b1;
    bus.rd_addr = 3'd1;
    #1;
    n_checks++;
    if (bus.data_out !== 16'h0000) begin
      n_fail++;
      $display("FAIL clr_during_write: got %h expected 0000", bus.data_out);
    end
    // Write port must work again once clear is released.
    write_word(3'd3, 16'hA5A5);
    bus.rd_addr = 3'd3;
    #1;
    n_checks++;
    if (bus.data_out !== 16'hA5A5) begin
      n_fail++;
      $display("FAIL write_after_clr: got %h expected a5a5", bus.data_out);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_clear();
    test_fill_readback();
    test_re_gating();
    test_write_disable();
    test_same_addr();
    test_clr_during_write();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
